// File: rtl/dmem_access_ctrl.sv
// Load/store controller between the MEM stage and a word-wide data memory.
// Sub-word stores use read-modify-write; loads return lane-extracted, extended data.
module dmem_access_ctrl #(
  parameter int ADDR_BITS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_addrLow;
  logic [15:0] r_wdata;
  logic        r_rspErr;
  logic [31:0] r_rspRdata;
  logic [31:0] r_memAddress;
  logic [31:0] r_memWriteData;

  logic        w_accept;
  logic        w_err;
  logic        w_wordStore;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadData;
  logic [31:0] w_merged;

  assign w_accept    = req_valid && (r_state == IDLE);
  assign w_wordStore = req_write && (req_size == 2'b10);
  assign w_err       = (req_size == 2'b11)
                    || ((req_size == 2'b01) && req_addr[0])
                    || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                    || (|req_addr[31:ADDR_BITS]);

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err)            w_next = RESP;
          else if (w_wordStore) w_next = WRITE;
          else                  w_next = READ;
        end
      end
      READ:    w_next = r_write ? WRITE : RESP;
      WRITE:   w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  // Lane extraction and store merge both work on the word returned during READ.
  always_comb begin
    w_byte = mem_read_data[{r_addrLow, 3'b000} +: 8];
    w_half = mem_read_data[{r_addrLow[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   w_loadData = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
      2'b01:   w_loadData = {{16{w_half[15] & ~r_unsigned}}, w_half};
      default: w_loadData = mem_read_data;
    endcase
    w_merged = mem_read_data;
    if (r_size == 2'b00) w_merged[{r_addrLow, 3'b000} +: 8] = r_wdata[7:0];
    else                 w_merged[{r_addrLow[1], 4'b0000} +: 16] = r_wdata;
  end

  // Response fields only change on the edge that enters RESP, so they hold between responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_write        <= 1'b0;
      r_size         <= 2'b00;
      r_unsigned     <= 1'b0;
      r_addrLow      <= 2'b00;
      r_wdata        <= 16'h0;
      r_rspErr       <= 1'b0;
      r_rspRdata     <= 32'h0;
      r_memAddress   <= 32'h0;
      r_memWriteData <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addrLow  <= req_addr[1:0];
            r_wdata    <= req_wdata[15:0];
            if (w_err) begin
              r_rspErr   <= 1'b1;
              r_rspRdata <= 32'h0;
            end else begin
              r_memAddress <= {req_addr[31:2], 2'b00};
              if (w_wordStore) r_memWriteData <= req_wdata;
            end
          end
        end
        READ: begin
          if (r_write) begin
            r_memWriteData <= w_merged;
          end else begin
            r_rspErr   <= 1'b0;
            r_rspRdata <= w_loadData;
          end
        end
        WRITE: begin
          r_rspErr   <= 1'b0;
          r_rspRdata <= 32'h0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready      = (r_state == IDLE);
  assign rsp_valid      = (r_state == RESP);
  assign mem_write      = (r_state == WRITE);
  assign rsp_err        = r_rspErr;
  assign rsp_rdata      = r_rspRdata;
  assign mem_address    = r_memAddress;
  assign mem_write_data = r_memWriteData;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a falling-edge word memory model.
module tb_dmem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic [31:0] mem_read_data;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int writeCount = 0;
  int rspCount = 0;
  int acceptCount = 0;
  int acceptAt [0:63];
  logic [31:0] lastWriteAddr = 32'h0;
  logic [31:0] lastWriteData = 32'h0;
  logic [31:0] mem [0:63];

  dmem_access_ctrl #(.ADDR_BITS(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write(mem_write),
    .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  // Memory samples on the falling edge, like the real dmemory32.
  always @(negedge clock) begin
    if (mem_write) begin
      mem[mem_address[7:2]] <= mem_write_data;
      lastWriteAddr <= mem_address;
      lastWriteData <= mem_write_data;
    end
    mem_read_data <= mem[mem_address[7:2]];
  end

  always @(posedge clock) begin
    cycle <= cycle + 1;
    if (mem_write) writeCount <= writeCount + 1;
    if (rsp_valid) rspCount <= rspCount + 1;
    if (req_valid && req_ready) begin
      acceptAt[acceptCount % 64] <= cycle;
      acceptCount <= acceptCount + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge in IDLE; returns at the falling edge where rsp_valid shows.
  task automatic applyStimulus(input logic w, input logic [1:0] s, input logic u,
                               input logic [31:0] a, input logic [31:0] d, output int lat);
    int guard;
    req_valid = 1'b1; req_write = w; req_size = s; req_unsigned = u;
    req_addr = a; req_wdata = d;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("acceptReady", {31'h0, req_ready}, 32'h1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic doRequest(input string tag, input logic w, input logic [1:0] s, input logic u,
                           input logic [31:0] a, input logic [31:0] d,
                           input int expLat, input logic expErr, input logic [31:0] expData);
    int lat;
    applyStimulus(w, s, u, a, d, lat);
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_err"}, {31'h0, rsp_err}, {31'h0, expErr});
    checkOutput({tag, "_data"}, rsp_rdata, expData);
    @(negedge clock);
  endtask

  initial begin
    int wc;
    int rc;
    int base;
    int idx;
    int rspSeen;
    int lowCycles;
    int budget;
    logic [31:0] b2bAddr [0:2];
    logic [31:0] b2bData [0:2];

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clock);
    checkOutput("rstReady", {31'h0, req_ready}, 32'h1);
    checkOutput("rstRspValid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("rstRspErr", {31'h0, rsp_err}, 32'h0);
    checkOutput("rstRdata", rsp_rdata, 32'h0);
    checkOutput("rstMemWrite", {31'h0, mem_write}, 32'h0);
    checkOutput("rstMemAddr", mem_address, 32'h0);
    checkOutput("rstMemWdata", mem_write_data, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    wc = writeCount;
    doRequest("wordStore", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0);
    checkOutput("wordStoreWrites", writeCount - wc, 1);
    checkOutput("wordStoreAddr", lastWriteAddr, 32'h10);
    checkOutput("wordStoreMem", mem[4], 32'hDEADBEEF);
    doRequest("wordLoad", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF);
    checkOutput("rdataHeld", rsp_rdata, 32'hDEADBEEF);

    doRequest("byteS13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFFDE);
    doRequest("byteU13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 1'b0, 32'h000000DE);
    doRequest("halfS12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 1'b0, 32'hFFFFDEAD);
    doRequest("halfU10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 2, 1'b0, 32'h0000BEEF);
    doRequest("byteS11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 2, 1'b0, 32'hFFFFFFBE);

    wc = writeCount;
    doRequest("byteStore", 1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55, 3, 1'b0, 32'h0);
    checkOutput("byteStoreWrites", writeCount - wc, 1);
    checkOutput("byteStoreWdata", lastWriteData, 32'hDEAD55EF);
    doRequest("byteStoreLoad", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEAD55EF);
    doRequest("halfStore", 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 3, 1'b0, 32'h0);
    doRequest("halfStoreLoad", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h123455EF);

    wc = writeCount;
    doRequest("errHalf11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1, 1'b1, 32'h0);
    doRequest("errWord12", 1'b1, 2'b10, 1'b0, 32'h12, 32'h0BADF00D, 1, 1'b1, 32'h0);
    doRequest("errSize", 1'b1, 2'b11, 1'b0, 32'h10, 32'h0BADF00D, 1, 1'b1, 32'h0);
    doRequest("errRange", 1'b1, 2'b00, 1'b0, 32'h00010000, 32'h0BADF00D, 1, 1'b1, 32'h0);
    checkOutput("errNoWrites", writeCount - wc, 0);
    doRequest("postErrLoad", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h123455EF);

    // Reset lands while the byte store is still in its read phase.
    wc = writeCount; rc = rspCount;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h00000077;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    checkOutput("midRstReady", {31'h0, req_ready}, 32'h1);
    checkOutput("midRstRspValid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("midRstMemAddr", mem_address, 32'h0);
    checkOutput("midRstRdata", rsp_rdata, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("midRstNoRsp", rspCount - rc, 0);
    checkOutput("midRstNoWrite", writeCount - wc, 0);
    checkOutput("midRstMem", mem[4], 32'h123455EF);

    b2bAddr[0] = 32'h20; b2bData[0] = 32'h11111111;
    b2bAddr[1] = 32'h24; b2bData[1] = 32'h22222222;
    b2bAddr[2] = 32'h28; b2bData[2] = 32'h33333333;
    for (int i = 0; i < 3; i++)
      doRequest("b2bPrep", 1'b1, 2'b10, 1'b0, b2bAddr[i], b2bData[i], 2, 1'b0, 32'h0);

    // Keep req_valid high across three loads and let req_ready pace them.
    base = acceptCount; idx = 0; rspSeen = 0; lowCycles = 0; budget = 0;
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    while ((idx < 3 || rspSeen < 3) && budget < 40) begin
      if (rsp_valid) begin
        if (rspSeen < 3) checkOutput("b2bData", rsp_rdata, b2bData[rspSeen]);
        rspSeen++;
      end
      if (req_ready) begin
        if (idx < 3) begin
          req_valid = 1'b1; req_addr = b2bAddr[idx]; idx++;
        end else begin
          req_valid = 1'b0;
        end
      end else if (idx == 3) begin
        req_valid = 1'b0;
      end else begin
        lowCycles++;
      end
      @(negedge clock);
      budget++;
    end
    req_valid = 1'b0;
    checkOutput("b2bRspCount", rspSeen, 3);
    checkOutput("b2bAccepts", acceptCount - base, 3);
    checkOutput("b2bReadyLow", lowCycles, 4);
    checkOutput("b2bGap1", acceptAt[(base + 1) % 64] - acceptAt[base % 64], 3);
    checkOutput("b2bGap2", acceptAt[(base + 2) % 64] - acceptAt[(base + 1) % 64], 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
